// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring, HLT latch and run gate,
// decoding the IR opcode into the 12-bit control word for the datapath.
module sap1_controller #(
  parameter logic [3:0] LDA_OP = 4'h0,
  parameter logic [3:0] ADD_OP = 4'h1,
  parameter logic [3:0] SUB_OP = 4'h2,
  parameter logic [3:0] OUT_OP = 4'hE,
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic       clk,
  input  logic       n_clr,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       n_lm,
  output logic       n_ce,
  output logic       n_li,
  output logic       n_ei,
  output logic       n_la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       n_lb,
  output logic       n_lo,
  output logic       halted,
  output logic [5:0] t_state
);

  localparam logic [5:0] T1 = 6'b000001;

  logic [5:0] ring;
  logic       halted_q;
  logic       legal;
  logic       is_lda, is_add, is_sub, is_out;

  assign legal   = (ring != 6'd0) && ((ring & (ring - 6'd1)) == 6'd0);
  assign t_state = ring;
  assign halted  = halted_q;

  always_ff @(posedge clk) begin
    if (!n_clr) begin
      ring     <= T1;
      halted_q <= 1'b0;
    end else if (!legal) begin
      ring <= T1;
    end else if (run && !halted_q) begin
      // HLT latches in T4 and freezes the ring there instead of rotating
      if (ring[3] && opcode == HLT_OP)
        halted_q <= 1'b1;
      else
        ring <= {ring[4:0], ring[5]};
    end
  end

  assign is_lda = (opcode == LDA_OP);
  assign is_add = (opcode == ADD_OP);
  assign is_sub = (opcode == SUB_OP);
  assign is_out = (opcode == OUT_OP);

  always_comb begin
    cp   = 1'b0;
    ep   = 1'b0;
    n_lm = 1'b1;
    n_ce = 1'b1;
    n_li = 1'b1;
    n_ei = 1'b1;
    n_la = 1'b1;
    ea   = 1'b0;
    su   = 1'b0;
    eu   = 1'b0;
    n_lb = 1'b1;
    n_lo = 1'b1;
    // reset, halt and a corrupt ring all leave the bus undriven
    if (n_clr && legal && !halted_q) begin
      if (ring[0]) begin
        ep   = 1'b1;
        n_lm = 1'b0;
      end
      if (ring[1])
        cp = 1'b1;
      if (ring[2]) begin
        n_ce = 1'b0;
        n_li = 1'b0;
      end
      if (ring[3]) begin
        if (is_lda || is_add || is_sub) begin
          n_ei = 1'b0;
          n_lm = 1'b0;
        end else if (is_out) begin
          ea   = 1'b1;
          n_lo = 1'b0;
        end
      end
      if (ring[4]) begin
        if (is_lda) begin
          n_ce = 1'b0;
          n_la = 1'b0;
        end else if (is_add || is_sub) begin
          n_ce = 1'b0;
          n_lb = 1'b0;
        end
      end
      if (ring[5] && (is_add || is_sub)) begin
        eu   = 1'b1;
        su   = is_sub;
        n_la = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for sap1_controller: ring sequencing, per-opcode decode,
// HLT freeze, run gating, mid-instruction reset and illegal-ring recovery.
module tb_sap1_controller;

  logic       clk, n_clr, run;
  logic [3:0] opcode;
  logic       cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo;
  logic       halted;
  logic [5:0] t_state;

  int n_tests = 0;
  int n_fail  = 0;

  // control word packing {cp,ep,n_lm,n_ce,n_li,n_ei,n_la,ea,su,eu,n_lb,n_lo}
  localparam logic [11:0] INACT = 12'h3E3;
  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;

  sap1_controller dut (
    .clk(clk), .n_clr(n_clr), .run(run), .opcode(opcode),
    .cp(cp), .ep(ep), .n_lm(n_lm), .n_ce(n_ce), .n_li(n_li), .n_ei(n_ei),
    .n_la(n_la), .ea(ea), .su(su), .eu(eu), .n_lb(n_lb), .n_lo(n_lo),
    .halted(halted), .t_state(t_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ctrl();
    return {cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo};
  endfunction

  // checks state, control word and the one-bus-driver rule together
  task automatic expect_st(input string tag, input logic [5:0] st, input logic [11:0] act);
    int drv;
    drv = int'(ep) + int'(!n_ce) + int'(!n_ei) + int'(ea) + int'(eu);
    check({tag, "_t"}, 32'(t_state), 32'(st));
    check({tag, "_ctl"}, 32'(ctrl()), 32'(INACT ^ act));
    check({tag, "_drv"}, 32'(drv <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_clr = 1'b0;
    step();
    n_clr = 1'b1;
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [3:0] op,
                           input logic [11:0] a4, input logic [11:0] a5, input logic [11:0] a6);
    logic [11:0] exp [6];
    exp[0] = EP | LM; exp[1] = CP; exp[2] = CE | LI;
    exp[3] = a4; exp[4] = a5; exp[5] = a6;
    opcode = op;
    run = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      expect_st($sformatf("%s_T%0d", tag, i + 1), 6'(1 << i), exp[i]);
      step();
    end
    check({tag, "_wrap"}, 32'(t_state), 32'h01);
  endtask

  initial begin
    n_clr = 1'b0; run = 1'b0; opcode = 4'h0;
    #1;
    check("rst_ctl_comb", 32'(ctrl()), 32'(INACT));
    step();
    check("rst_t", 32'(t_state), 32'h01);
    check("rst_halt", 32'(halted), 32'd0);
    n_clr = 1'b1;

    run_instr("lda", 4'h0, EI | LM, CE | LA, 12'h000);
    run_instr("sub", 4'h2, EI | LM, CE | LB, EU | SU | LA);
    run_instr("add", 4'h1, EI | LM, CE | LB, EU | LA);
    run_instr("out", 4'hE, EA | LO, 12'h000, 12'h000);
    run_instr("nop7", 4'h7, 12'h000, 12'h000, 12'h000);

    // HLT: latch at T4, then freeze with everything inactive
    opcode = 4'hF; run = 1'b1;
    step(); step(); step();
    expect_st("hlt_T4", 6'h08, 12'h000);
    check("hlt_pre", 32'(halted), 32'd0);
    step();
    check("hlt_set", 32'(halted), 32'd1);
    expect_st("hlt_frz0", 6'h08, 12'h000);
    opcode = 4'h1;
    for (int i = 0; i < 20; i++) step();
    expect_st("hlt_frz20", 6'h08, 12'h000);
    check("hlt_still", 32'(halted), 32'd1);
    n_clr = 1'b0;
    step();
    check("hlt_clr_t", 32'(t_state), 32'h01);
    check("hlt_clr_h", 32'(halted), 32'd0);
    n_clr = 1'b1;

    // run gate held in T3
    opcode = 4'h0; run = 1'b1;
    step(); step();
    run = 1'b0;
    for (int i = 0; i < 5; i++) step();
    expect_st("hold_T3", 6'h04, CE | LI);
    run = 1'b1;
    step();
    expect_st("resume_T4", 6'h08, EI | LM);

    // reset mid-ADD at T5
    do_reset();
    opcode = 4'h1; run = 1'b1;
    for (int i = 0; i < 4; i++) step();
    expect_st("add_T5", 6'h10, CE | LB);
    n_clr = 1'b0;
    #1;
    check("midrst_ctl", 32'(ctrl()), 32'(INACT));
    check("midrst_tq", 32'(t_state), 32'h10);
    step();
    check("midrst_t", 32'(t_state), 32'h01);
    n_clr = 1'b1;

    // illegal ring recovers to T1 even with run=0
    run = 1'b0;
    #1;
    force dut.ring = 6'b000011;
    #1;
    expect_st("illegal", 6'h03, 12'h000);
    release dut.ring;
    step();
    check("illegal_rec", 32'(t_state), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sap1_controller.md
Name: sap1_controller

Overview:
- Controller-sequencer for the SAP-1 datapath.
- A 6-state one-hot ring counter (T1..T6) sequences fetch and execute for each instruction.
- The opcode from the instruction register is decoded into the 12-bit control word that drives the program counter, MAR, RAM, IR, accumulator, ALU, B register and output register.
- Also owns the HLT latch and a run gate, so the bench can single-cycle the machine.

Parameters:
- LDA_OP, 4'h0, opcode of LDA.
- ADD_OP, 4'h1, opcode of ADD.
- SUB_OP, 4'h2, opcode of SUB.
- OUT_OP, 4'hE, opcode of OUT.
- HLT_OP, 4'hF, opcode of HLT.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- n_clr  input  1  reset, synchronous, active-low.
- run  input  1  ring advances only on a posedge where run=1.
- opcode  input  4  IR upper nibble; valid from T4 onward.
- cp  output  1  PC increment.
- ep  output  1  PC drive bus.
- n_lm  output  1  MAR load, active-low.
- n_ce  output  1  RAM drive bus, active-low.
- n_li  output  1  IR load, active-low.
- n_ei  output  1  IR drive low nibble to bus, active-low.
- n_la  output  1  A load, active-low.
- ea  output  1  A drive bus.
- su  output  1  ALU subtract select.
- eu  output  1  ALU drive bus.
- n_lb  output  1  B load, active-low.
- n_lo  output  1  output register load, active-low.
- halted  output  1  HLT executed.
- t_state  output  6  one-hot ring; bit0=T1 .. bit5=T6.

Behaviour:
- State: 6-bit ring plus 1-bit halted register, both updated on posedge clk only.
- Reset (n_clr=0 at posedge): ring=6'b000001 (T1), halted=0. Reset overrides run, halted and illegal states, and works mid-instruction.
- Combinational override while n_clr=0: all control outputs inactive (active-high=0, active-low=1); t_state and halted still show register values.
- Advance: when run=1 and halted=0, ring rotates T1->T2->...->T6->T1 each posedge.
  - run=0: ring holds, control word stays decoded for the held state.
- Illegal ring value (not one-hot): next posedge with n_clr=1 loads T1 regardless of run; control word all inactive while illegal.
- Control word is decoded combinationally from ring and opcode, with zero latency. Unlisted signals are inactive.
  - T1: ep=1, n_lm=0.
  - T2: cp=1.
  - T3: n_ce=0, n_li=0.
  - T4, LDA/ADD/SUB: n_ei=0, n_lm=0.
  - T4, OUT: ea=1, n_lo=0.
  - T4, HLT: all inactive.
  - T5, LDA: n_ce=0, n_la=0.
  - T5, ADD/SUB: n_ce=0, n_lb=0.
  - T6, ADD: eu=1, n_la=0, su=0.
  - T6, SUB: eu=1, su=1, n_la=0.
  - Any other opcode in T4-T6: NOP, all inactive; the ring still runs through T6.
- HLT: at a posedge in T4 with opcode=HLT_OP and run=1, halted<=1 and ring stays T4.
  - Once halted=1, the ring freezes and the control word is forced all inactive regardless of state and opcode.
  - Only n_clr=0 clears halted.
- Single-driver guarantee: in every state at most one of ep, n_ce(low), n_ei(low), ea, eu is active. The bench asserts this every cycle.
- cp is a one-cycle pulse per instruction, asserted only in T2, so the PC advances exactly once per 6 run cycles.

Test Plan:
- Reset then hold run=1, opcode=LDA_OP, for 6 cycles -> t_state=01,02,04,08,10,20 hex. Per state: T1 ep=1,n_lm=0; T2 cp=1; T3 n_ce=0,n_li=0; T4 n_ei=0,n_lm=0; T5 n_ce=0,n_la=0; T6 all inactive. Cycle 7 returns to T1 (01).
- opcode=SUB_OP, run=1 -> T5 n_lb=0; T6 eu=1, su=1, n_la=0. Repeat with ADD_OP -> T6 su=0, eu=1.
- opcode=OUT_OP -> T4 ea=1, n_lo=0, all other enables inactive. opcode=4'h7 -> T4-T6 all inactive, ring completes to T1.
- opcode=HLT_OP, run to T4 -> after that posedge halted=1 and t_state=08. Then 20 more cycles with run=1 -> t_state=08, all controls inactive. Pull n_clr=0 one cycle -> t_state=01, halted=0.
- run=0 in T3 for 5 cycles -> t_state stays 04 with n_ce=0, n_li=0 held. run=1 -> next posedge T4.
- n_clr=0 at T5 mid-ADD -> same cycle all controls inactive; after posedge t_state=01. Force an illegal ring value of 6'b000011 via the bench with run=0 -> next posedge t_state=01.
